// File: rtl/reg_writeback_arb.sv
// Register-file write-port arbiter: ALU results take priority, and memory results are buffered in a small FIFO.
// Also tracks which registers still have an outstanding memory-sourced write (PEND).
module reg_writeback_arb #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ALU_VALID,
  input  logic [4:0]       ALU_WA,
  input  logic [31:0]      ALU_WD,
  input  logic             MEM_VALID,
  output logic             MEM_READY,
  input  logic [4:0]       MEM_WA,
  input  logic [31:0]      MEM_WD,
  input  logic             ISSUE_VALID,
  input  logic [4:0]       ISSUE_RD,
  output logic             RF_EN,
  output logic [4:0]       RF_WA,
  output logic [31:0]      RF_WD,
  output logic [31:0]      PEND,
  output logic [PTR_W:0]   FIFO_CNT
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [4:0]       fifo_wa [DEPTH];
  logic [31:0]      fifo_wd [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   cnt_reg;
  logic [31:0]      pend_reg;
  logic             rf_en_reg;
  logic [4:0]       rf_wa_reg;
  logic [31:0]      rf_wd_reg;

  logic             alu_w;
  logic             mem_acc;
  logic             fifo_empty;
  logic             pop;
  logic             bypass;
  logic             push;
  logic             commit_en;
  logic [4:0]       commit_wa;
  logic [31:0]      commit_wd;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic [31:0]      pend_next;

  assign MEM_READY = (cnt_reg != FULL_CNT);

  always_comb begin
    alu_w      = ALU_VALID && (ALU_WA != 5'd0);
    mem_acc    = MEM_VALID && MEM_READY;
    fifo_empty = (cnt_reg == '0);
    pop        = !alu_w && !fifo_empty;
    // Bypass only when the FIFO is empty, so memory results stay in acceptance order
    bypass     = !alu_w && fifo_empty && mem_acc && (MEM_WA != 5'd0);
    push       = mem_acc && (MEM_WA != 5'd0) && !bypass;
    commit_en  = alu_w || pop || bypass;

    commit_wa = ALU_WA;
    commit_wd = ALU_WD;
    clr_mask  = 32'd0;
    if (!alu_w) begin
      if (pop) begin
        commit_wa = fifo_wa[rd_ptr_reg];
        commit_wd = fifo_wd[rd_ptr_reg];
      end else begin
        commit_wa = MEM_WA;
        commit_wd = MEM_WD;
      end
      if (pop || bypass) clr_mask = 32'd1 << commit_wa;
    end

    set_mask = (ISSUE_VALID && (ISSUE_RD != 5'd0)) ? (32'd1 << ISSUE_RD) : 32'd0;
    // Set is applied after clear so a same-cycle reissue keeps the register pending
    pend_next    = (pend_reg & ~clr_mask) | set_mask;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_wa[wr_ptr_reg] <= MEM_WA;
      fifo_wd[wr_ptr_reg] <= MEM_WD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
      pend_reg   <= 32'd0;
      rf_en_reg  <= 1'b0;
      rf_wa_reg  <= 5'd0;
      rf_wd_reg  <= 32'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_ONE;
        2'b01:   cnt_reg <= cnt_reg - CNT_ONE;
        default: cnt_reg <= cnt_reg;
      endcase
      pend_reg  <= pend_next;
      rf_en_reg <= commit_en;
      if (commit_en) begin
        rf_wa_reg <= commit_wa;
        rf_wd_reg <= commit_wd;
      end
    end
  end

  assign RF_EN    = rf_en_reg;
  assign RF_WA    = rf_wa_reg;
  assign RF_WD    = rf_wd_reg;
  assign PEND     = pend_reg;
  assign FIFO_CNT = cnt_reg;

  a_no_x0_write: assert property (@(posedge CLK) disable iff (RST) RF_EN |-> (RF_WA != 5'd0));
  a_cnt_bound:   assert property (@(posedge CLK) disable iff (RST) cnt_reg <= FULL_CNT);

endmodule

// File: tb/tb_reg_writeback_arb.sv
// Bench for reg_writeback_arb: directed scenarios plus random traffic, all against a queue-based reference model.
module tb_reg_writeback_arb;
  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic CLK = 1'b0;
  logic RST, ALU_VALID, MEM_VALID, MEM_READY, ISSUE_VALID, RF_EN;
  logic [4:0] ALU_WA, MEM_WA, ISSUE_RD, RF_WA;
  logic [31:0] ALU_WD, MEM_WD, RF_WD, PEND;
  logic [PTR_W:0] FIFO_CNT;

  reg_writeback_arb #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_VALID(ALU_VALID), .ALU_WA(ALU_WA), .ALU_WD(ALU_WD),
    .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY), .MEM_WA(MEM_WA), .MEM_WD(MEM_WD),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
    .RF_EN(RF_EN), .RF_WA(RF_WA), .RF_WD(RF_WD), .PEND(PEND), .FIFO_CNT(FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  // Reference model: pending memory results in a queue, pending registers as a bit vector
  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_en;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare every output against it
  task automatic step(input bit rst, input bit av, input logic [4:0] awa, input logic [31:0] awd,
                      input bit mv, input logic [4:0] mwa, input logic [31:0] mwd,
                      input bit iv, input logic [4:0] ird, output bit acc);
    bit   rdy, alu_w, busy;
    ent_t e;
    RST = rst; ALU_VALID = av; ALU_WA = awa; ALU_WD = awd;
    MEM_VALID = mv; MEM_WA = mwa; MEM_WD = mwd; ISSUE_VALID = iv; ISSUE_RD = ird;
    rdy = (m_q.size() < DEPTH);
    if (!rst) chk("mem_ready", {31'd0, MEM_READY}, {31'd0, rdy});
    acc = mv && rdy && !rst;
    @(posedge CLK);
    if (rst) begin
      m_q.delete(); m_pend = 0; m_en = 0; m_wa = 0; m_wd = 0;
    end else begin
      alu_w = av && (awa != 0);
      busy  = (m_q.size() != 0);
      m_en  = 0;
      if (alu_w) begin
        m_en = 1; m_wa = awa; m_wd = awd;
      end else if (busy) begin
        e = m_q.pop_front();
        m_en = 1; m_wa = e.wa; m_wd = e.wd; m_pend[e.wa] = 1'b0;
      end else if (acc && mwa != 0) begin
        m_en = 1; m_wa = mwa; m_wd = mwd; m_pend[mwa] = 1'b0;
      end
      // The beat takes the bypass path only when it was itself committed
      if (acc && mwa != 0 && (alu_w || busy)) begin
        e.wa = mwa; e.wd = mwd; m_q.push_back(e);
      end
      if (iv && ird != 0) m_pend[ird] = 1'b1;
    end
    #1;
    chk("rf_en", {31'd0, RF_EN}, {31'd0, m_en});
    chk("rf_wa", {27'd0, RF_WA}, {27'd0, m_wa});
    chk("rf_wd", RF_WD, m_wd);
    chk("pend", PEND, m_pend);
    chk("fifo_cnt", 32'(FIFO_CNT), 32'(m_q.size()));
    if (RF_EN) $display("t=%0t commit x%0d = %h", $time, RF_WA, RF_WD);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  initial begin
    bit a;
    int idx;
    logic [4:0] mlist [3];
    logic [4:0] wexp [7];

    // Reset followed by an idle cycle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, a);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, a);
    idle(1);
    chk("rst_en", {31'd0, RF_EN}, 32'd0);
    chk("rst_pend", PEND, 32'd0);
    chk("rst_cnt", 32'(FIFO_CNT), 32'd0);
    chk("rst_ready", {31'd0, MEM_READY}, 32'd1);

    // ALU write appears exactly one cycle later, then drops
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, a);
    chk("alu_en", {31'd0, RF_EN}, 32'd1);
    chk("alu_wa", {27'd0, RF_WA}, 32'd5);
    chk("alu_wd", RF_WD, 32'hDEADBEEF);
    idle(1);
    chk("alu_en_drop", {31'd0, RF_EN}, 32'd0);

    // Issue x7, then a bypassed memory beat to x7 clears it
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, a);
    chk("pend7_set", {31'd0, PEND[7]}, 32'd1);
    idle(2);
    step(0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, a);
    chk("byp_wa", {27'd0, RF_WA}, 32'd7);
    chk("byp_wd", RF_WD, 32'h1234);
    chk("pend7_clr", {31'd0, PEND[7]}, 32'd0);

    // ALU x1..x4 while memory offers x10..x12 under backpressure
    mlist[0] = 10; mlist[1] = 11; mlist[2] = 12;
    wexp[0] = 1; wexp[1] = 2; wexp[2] = 3; wexp[3] = 4; wexp[4] = 10; wexp[5] = 11; wexp[6] = 12;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      step(0, c < 4, 5'(c + 1), 32'(c + 100), idx < 3, (idx < 3) ? mlist[idx] : 5'd0,
           32'(idx + 200), 0, 0, a);
      if (c == 2 || c == 3) begin
        chk("bp_cnt", 32'(FIFO_CNT), 32'd2);
        chk("bp_ready", {31'd0, MEM_READY}, 32'd0);
      end
      if (a) idx++;
      chk("order_wa", {27'd0, RF_WA}, {27'd0, wexp[c]});
    end
    idle(1);

    // x0 handling
    step(0, 0, 0, 0, 1, 0, 32'h55, 0, 0, a);
    chk("x0_mem_en", {31'd0, RF_EN}, 32'd0);
    chk("x0_mem_cnt", 32'(FIFO_CNT), 32'd0);
    step(0, 1, 1, 32'h11, 1, 9, 32'h99, 1, 0, a);
    chk("x0_issue", PEND, 32'd0);
    step(0, 1, 0, 32'h77, 0, 0, 0, 0, 0, a);
    chk("x0_alu_wa", {27'd0, RF_WA}, 32'd9);
    chk("x0_alu_wd", RF_WD, 32'h99);

    // Same-cycle issue and memory commit to x3: the set wins
    step(0, 1, 2, 32'h22, 1, 3, 32'h33, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, a);
    chk("setwin_wa", {27'd0, RF_WA}, 32'd3);
    chk("setwin_pend", {31'd0, PEND[3]}, 32'd1);

    // Reset with buffered entries: they must never be written
    step(0, 1, 1, 32'h1, 1, 20, 32'h20, 0, 0, a);
    step(0, 1, 2, 32'h2, 1, 21, 32'h21, 0, 0, a);
    chk("mid_cnt", 32'(FIFO_CNT), 32'd2);
    chk("mid_en", {31'd0, RF_EN}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, a);
    chk("mid_rst_en", {31'd0, RF_EN}, 32'd0);
    chk("mid_rst_cnt", 32'(FIFO_CNT), 32'd0);
    chk("mid_rst_pend", PEND, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("mid_no_ghost", {31'd0, RF_EN}, 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
           $urandom,
           $urandom_range(0, 2) != 0,
           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
           $urandom,
           $urandom_range(0, 3) == 0,
           5'($urandom),
           a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_writeback_arb.md
Name: reg_writeback_arb

Overview:
- Write-side front end for the OTTER register file. It merges single-cycle ALU results and variable-latency memory/multicycle results into the single register-file write port.
- It drives the port's enable, write address and write data. It also keeps a pending-write scoreboard that the hazard logic reads.
- The ALU source is never stalled. The memory source uses a valid/ready handshake backed by a small FIFO.

Parameters:
- DEPTH, 2, number of memory-result FIFO entries (power of two, ≥2)
- PTR_W, $clog2(DEPTH), FIFO pointer width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- ALU_VALID  in  1  ALU result present this cycle
- ALU_WA  in  5  ALU destination register
- ALU_WD  in  32  ALU result data
- MEM_VALID  in  1  memory/multicycle result offered
- MEM_READY  out  1  arbiter can accept the memory result
- MEM_WA  in  5  memory result destination register
- MEM_WD  in  32  memory result data
- ISSUE_VALID  in  1  a long-latency op targeting ISSUE_RD was issued
- ISSUE_RD  in  5  destination of the issued long-latency op
- RF_EN  out  1  register-file write enable
- RF_WA  out  5  register-file write address
- RF_WD  out  32  register-file write data
- PEND  out  32  bit r = 1: a memory write to xr is outstanding
- FIFO_CNT  out  PTR_W+1  occupied FIFO entries

Behaviour:
- Reset: RF_EN=0, RF_WA=0, RF_WD=0, PEND=0, FIFO_CNT=0, FIFO pointers=0. MEM_READY=1 in the cycle after reset. Reset mid-operation discards all buffered entries.
- Definitions:
  - alu_w = ALU_VALID && ALU_WA!=0.
  - mem_acc = MEM_VALID && MEM_READY.
  - MEM_READY = !full, combinational from FIFO_CNT.
- Commit selection each cycle, priority order:
  1. alu_w: commit the ALU result.
  2. Else if FIFO non-empty: commit the FIFO head (pop).
  3. Else if mem_acc && MEM_WA!=0: commit the incoming beat directly (bypass, not pushed).
  4. Else: no commit.
- Outputs RF_EN/RF_WA/RF_WD are registered: a result committed in cycle N appears in cycle N+1 for exactly one cycle. RF_EN=0 when nothing commits; RF_WA/RF_WD hold their last values.
- Push rule: an accepted memory beat with MEM_WA!=0 that is not bypassed is pushed to the FIFO tail.
- x0 handling:
  - An accepted memory beat with MEM_WA==0 is consumed and discarded. It is not pushed and produces no commit.
  - ALU_VALID with ALU_WA==0 is treated as no ALU write, so the FIFO may drain that cycle.
  - RF_EN never asserts with RF_WA==0.
- Full FIFO + ALU write: MEM_READY=0 and no pop occurs, so the memory side is backpressured. The ALU is never stalled.
- Simultaneous push and pop on a full FIFO is not possible, because MEM_READY=0 when full.
- Simultaneous push and pop on a non-full FIFO leaves FIFO_CNT unchanged. Pointers wrap modulo DEPTH.
- Ordering: memory results commit strictly in acceptance order. ALU-vs-memory ordering to the same register is the hazard unit's responsibility, using PEND, and is not checked here.
- Scoreboard:
  - ISSUE_VALID && ISSUE_RD!=0 sets PEND[ISSUE_RD] at the next edge.
  - A memory-sourced commit to xr clears PEND[r] at the same edge the write is registered to RF_*.
  - If a set and a clear target the same register in the same cycle, the set wins.
  - PEND[0] is constant 0.
  - ALU commits never change PEND.
- Register-file write timing: RF_* feed the register file's synchronous write. The write is visible to reads in cycle N+2 relative to commit cycle N.

Test Plan:
- Reset, idle: RST=1 for 2 cycles, then all inputs 0 → RF_EN=0, PEND=0, FIFO_CNT=0, MEM_READY=1.
- ALU latency: ALU_VALID=1, WA=5, WD=0xDEADBEEF in cycle N → RF_EN=1, RF_WA=5, RF_WD=0xDEADBEEF in cycle N+1 only.
- Bypass plus scoreboard clear:
  - ISSUE_VALID=1, RD=7 in cycle 0 → PEND[7]=1 from cycle 1.
  - MEM beat WA=7, WD=0x1234 in cycle 3 with FIFO empty and no ALU → RF write x7=0x1234 in cycle 4, PEND[7]=0 from cycle 4.
- Contention and backpressure (DEPTH=2):
  - ALU writes x1..x4 in cycles 0–3 while MEM offers x10, x11, x12 from cycle 0 → x10 and x11 buffered, FIFO_CNT=2, MEM_READY=0 in cycles 2–3.
  - Commits are x1, x2, x3, x4, then x10 (cycle 5), x11 (cycle 6), x12 (cycle 7).
- x0 handling:
  - MEM beat WA=0 → accepted, FIFO_CNT unchanged, no RF_EN.
  - ALU_VALID with WA=0 and FIFO holding x9 → x9 commits next cycle.
  - ISSUE_RD=0 → PEND stays 0.
- Reset mid-operation: FIFO_CNT=2 and RF_EN=1, assert RST for 1 cycle → next cycle RF_EN=0, FIFO_CNT=0, PEND=0, and the buffered writes never appear. Also check set-wins: same-cycle ISSUE x3 and memory commit to x3 → PEND[3]=1.
